// File: rtl/nios_handshake_oci_pkg.sv
// Shared constants and FSM state type for the OCI trace (DCT) packer.
package nios_handshake_oci_pkg;

    localparam int ATOM_W    = 2;
    localparam int ATOMS     = 15;
    localparam int CNT_W     = 4;
    localparam int DCT_BUF_W = ATOM_W * ATOMS;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        ENDED = 2'd2
    } dct_state_t;

endpackage

// File: rtl/nios_handshake_nios2_qsys_0_oci_dct_outreg.sv
// Single-entry output holding register for DCT frames: valid/ready handshake
// plus a wrapping count of frames accepted by the sink.
module nios_handshake_nios2_qsys_0_oci_dct_outreg
    import nios_handshake_oci_pkg::*;
#(
    parameter int FCNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 load,
    input  logic [DCT_BUF_W-1:0] load_buf,
    input  logic [CNT_W-1:0]     load_cnt,
    input  logic                 dct_ready,
    output logic                 out_free,
    output logic                 dct_valid,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]     dct_count,
    output logic [FCNT_W-1:0]    frame_cnt
);

    logic                 valid_q, valid_d;
    logic [DCT_BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FCNT_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic                 handshake;

    always_comb begin
        out_free  = !valid_q | dct_ready;
        handshake = valid_q & dct_ready;
        valid_d   = valid_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        // A load in the same cycle as a handshake replaces the frame back-to-back
        if (load) begin
            valid_d = 1'b1;
            buf_d   = load_buf;
            cnt_d   = load_cnt;
        end else if (handshake) begin
            valid_d = 1'b0;
        end
        frame_cnt_d = frame_cnt_q + FCNT_W'(handshake);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            buf_q       <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign dct_valid  = valid_q;
    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: rtl/nios_handshake_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT frames and sequences end-of-test drain.
//   state | meaning
//   RUN   | accepting atoms, frames emitted when full or flushed
//   DRAIN | no new atoms; last partial frame pushed out, waiting for sink
//   ENDED | drain complete; terminal until reset
module nios_handshake_nios2_qsys_0_oci_dct_packer
    import nios_handshake_oci_pkg::*;
#(
    parameter int FCNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 atom_valid,
    output logic                 atom_ready,
    input  logic [ATOM_W-1:0]    atom_data,
    input  logic                 flush,
    input  logic                 end_req,
    output logic                 dct_valid,
    input  logic                 dct_ready,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0]     dct_count,
    output logic                 test_ending,
    output logic                 test_has_ended,
    output logic [FCNT_W-1:0]    frame_cnt
);

    localparam logic [CNT_W-1:0] ATOMS_C = CNT_W'(ATOMS);

    dct_state_t           state_q, state_d;
    logic [DCT_BUF_W-1:0] acc_buf_q, acc_buf_d;
    logic [CNT_W-1:0]     acc_cnt_q, acc_cnt_d;
    logic                 flush_pend_q, flush_pend_d;

    logic                 accept;
    logic                 frame_ready;
    logic                 transfer;
    logic                 out_free;
    logic [CNT_W-1:0]     post_cnt;

    always_comb begin
        frame_ready = (acc_cnt_q == ATOMS_C) | flush_pend_q
                    | ((state_q == DRAIN) && (acc_cnt_q != '0));
        atom_ready  = (state_q == RUN) & !frame_ready;
        accept      = atom_valid & atom_ready;
        transfer    = frame_ready & out_free;
        post_cnt    = acc_cnt_q + CNT_W'(accept);
    end

    always_comb begin
        acc_buf_d    = acc_buf_q;
        acc_cnt_d    = acc_cnt_q;
        flush_pend_d = flush_pend_q;
        // transfer and accept are mutually exclusive: accept needs !frame_ready
        if (transfer) begin
            acc_buf_d    = '0;
            acc_cnt_d    = '0;
            flush_pend_d = 1'b0;
        end else begin
            if (accept) begin
                acc_buf_d[int'(acc_cnt_q) * ATOM_W +: ATOM_W] = atom_data;
                acc_cnt_d = post_cnt;
            end
            if (flush && (state_q != ENDED) && (post_cnt != '0)) begin
                flush_pend_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (end_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Empty accumulator implies no pending transfer; only the sink matters
                if ((acc_cnt_q == '0) && !flush_pend_q && out_free) begin
                    state_d = ENDED;
                end
            end
            ENDED:   state_d = ENDED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            acc_buf_q    <= '0;
            acc_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_buf_q    <= acc_buf_d;
            acc_cnt_q    <= acc_cnt_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign test_ending    = (state_q == DRAIN);
    assign test_has_ended = (state_q == ENDED);

    nios_handshake_nios2_qsys_0_oci_dct_outreg #(
        .FCNT_W (FCNT_W)
    ) u_outreg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (transfer),
        .load_buf   (acc_buf_q),
        .load_cnt   (acc_cnt_q),
        .dct_ready  (dct_ready),
        .out_free   (out_free),
        .dct_valid  (dct_valid),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .frame_cnt  (frame_cnt)
    );

endmodule

// File: tb/tb_nios_handshake_nios2_qsys_0_oci_dct_packer.sv
// Scoreboard bench for the DCT packer; a second instance with FCNT_W=2 shares the stimulus.
module tb_nios_handshake_nios2_qsys_0_oci_dct_packer;
    import nios_handshake_oci_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        atom_valid = 1'b0;
    logic [1:0]  atom_data = 2'd0;
    logic        flush = 1'b0;
    logic        end_req = 1'b0;
    logic        dct_ready = 1'b0;

    logic        atom_ready, dct_valid, test_ending, test_has_ended;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [15:0] frame_cnt;

    logic        u2_atom_ready, u2_dct_valid, u2_test_ending, u2_test_has_ended;
    logic [29:0] u2_dct_buffer;
    logic [3:0]  u2_dct_count;
    logic [1:0]  u2_frame_cnt;

    nios_handshake_nios2_qsys_0_oci_dct_packer #(.FCNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom_ready(atom_ready),
        .atom_data(atom_data), .flush(flush), .end_req(end_req), .dct_valid(dct_valid),
        .dct_ready(dct_ready), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .test_ending(test_ending), .test_has_ended(test_has_ended), .frame_cnt(frame_cnt)
    );

    nios_handshake_nios2_qsys_0_oci_dct_packer #(.FCNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .atom_valid(atom_valid), .atom_ready(u2_atom_ready),
        .atom_data(atom_data), .flush(flush), .end_req(end_req), .dct_valid(u2_dct_valid),
        .dct_ready(dct_ready), .dct_buffer(u2_dct_buffer), .dct_count(u2_dct_count),
        .test_ending(u2_test_ending), .test_has_ended(u2_test_has_ended),
        .frame_cnt(u2_frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] b;
        logic [3:0]  c;
    } frame_t;

    frame_t sb[$];
    frame_t mon_f;
    int n_tests = 0;
    int n_fail  = 0;

    logic [29:0] t6_exp [5] = '{30'h0000_0000, 30'h1555_5555, 30'h2AAA_AAAA,
                                30'h3FFF_FFFF, 30'h0000_0000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [29:0] b, input logic [3:0] c);
        frame_t f;
        f.b = b;
        f.c = c;
        sb.push_back(f);
    endtask

    // Monitor: pop on handshake, and check stability while the sink stalls
    logic        hold_v = 1'b0;
    logic [29:0] hold_b = '0;
    logic [3:0]  hold_c = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (dct_valid && dct_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_frame", {28'd0, dct_count}, 32'd0);
                end else begin
                    mon_f = sb.pop_front();
                    chk("frame_buffer", {2'b0, dct_buffer}, {2'b0, mon_f.b});
                    chk("frame_count", {28'd0, dct_count}, {28'd0, mon_f.c});
                end
            end
            if (dct_valid && !dct_ready && hold_v) begin
                chk("hold_buffer", {2'b0, dct_buffer}, {2'b0, hold_b});
                chk("hold_count", {28'd0, dct_count}, {28'd0, hold_c});
            end
            hold_v = dct_valid && !dct_ready;
            hold_b = dct_buffer;
            hold_c = dct_count;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_atom(input logic [1:0] d);
        int w = 0;
        atom_valid = 1'b1;
        atom_data  = d;
        while (!atom_ready && w < 100) begin
            step(1);
            w++;
        end
        if (!atom_ready) begin
            chk("atom_accept_timeout", 32'd0, 32'd1);
            atom_valid = 1'b0;
            return;
        end
        step(1);
        atom_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int w = 0;
        while ((sb.size() != 0 || dct_valid) && w < 300) begin
            step(1);
            w++;
        end
        chk(name, {31'd0, (sb.size() == 0) && !dct_valid}, 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sb.delete();
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dct_ready = 1'b1;
        step(2);
        chk("rst_dct_valid", {31'd0, dct_valid}, 32'd0);
        chk("rst_dct_count", {28'd0, dct_count}, 32'd0);
        chk("rst_dct_buffer", {2'b0, dct_buffer}, 32'd0);
        chk("rst_test_ending", {31'd0, test_ending}, 32'd0);
        chk("rst_test_has_ended", {31'd0, test_has_ended}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_frame_cnt_w2", {30'd0, u2_frame_cnt}, 32'd0);
        reset_n = 1'b1;
        step(1);

        // 1: full frame of 0,1,2,3,...
        push(30'h24E4E4E4, 4'd15);
        for (int k = 0; k < 15; k++) send_atom(2'(k));
        chk("t1_valid_at_full", {31'd0, dct_valid}, 32'd0);
        step(1);
        chk("t1_valid_next_edge", {31'd0, dct_valid}, 32'd1);
        wait_drain("t1_drain");
        chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // 2: partial frame closed by flush, then flush while empty
        push(30'h0000001F, 4'd3);
        send_atom(2'd3);
        send_atom(2'd3);
        send_atom(2'd1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        wait_drain("t2_drain");
        chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd2);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        step(5);
        chk("t2_empty_flush_cnt", {16'd0, frame_cnt}, 32'd2);
        chk("t2_empty_flush_valid", {31'd0, dct_valid}, 32'd0);

        // 3: backpressure, 30 atoms with sink stalled
        dct_ready = 1'b0;
        push(30'h1B1B1B1B, 4'd15);
        push(30'h2AAAAAAA, 4'd15);
        for (int k = 0; k < 15; k++) send_atom(2'(3 - (k % 4)));
        for (int k = 0; k < 15; k++) send_atom(2'd2);
        chk("t3_stall_atom_ready", {31'd0, atom_ready}, 32'd0);
        chk("t3_held_count", {28'd0, dct_count}, 32'd15);
        step(4);
        chk("t3_still_stalled", {31'd0, atom_ready}, 32'd0);
        dct_ready = 1'b1;
        wait_drain("t3_drain");
        chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'd4);

        // 4: end-of-test drain with a 5-atom partial frame
        dct_ready = 1'b0;
        push(30'h00000155, 4'd5);
        for (int k = 0; k < 5; k++) send_atom(2'd1);
        end_req = 1'b1;
        step(1);
        end_req = 1'b0;
        chk("t4_test_ending", {31'd0, test_ending}, 32'd1);
        chk("t4_atom_ready_drain", {31'd0, atom_ready}, 32'd0);
        chk("t4_not_ended_yet", {31'd0, test_has_ended}, 32'd0);
        step(3);
        chk("t4_valid_partial", {31'd0, dct_valid}, 32'd1);
        chk("t4_count_partial", {28'd0, dct_count}, 32'd5);
        chk("t4_not_ended_stalled", {31'd0, test_has_ended}, 32'd0);
        dct_ready = 1'b1;
        step(1);
        chk("t4_has_ended", {31'd0, test_has_ended}, 32'd1);
        chk("t4_ending_cleared", {31'd0, test_ending}, 32'd0);
        chk("t4_valid_dropped", {31'd0, dct_valid}, 32'd0);
        chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'd5);
        atom_valid = 1'b1;
        flush = 1'b1;
        end_req = 1'b1;
        step(3);
        chk("t4_ended_atom_ready", {31'd0, atom_ready}, 32'd0);
        atom_valid = 1'b0;
        flush = 1'b0;
        end_req = 1'b0;
        step(3);
        chk("t4_ended_no_frame", {31'd0, dct_valid}, 32'd0);
        chk("t4_ended_sticky", {31'd0, test_has_ended}, 32'd1);
        chk("t4_ended_frame_cnt", {16'd0, frame_cnt}, 32'd5);

        // 5: asynchronous reset while a frame is presented
        do_reset();
        dct_ready = 1'b0;
        for (int k = 0; k < 15; k++) send_atom(2'd1);
        for (int w = 0; w < 10 && !dct_valid; w++) step(1);
        chk("t5_valid_before_reset", {31'd0, dct_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_async_valid", {31'd0, dct_valid}, 32'd0);
        chk("t5_async_count", {28'd0, dct_count}, 32'd0);
        chk("t5_async_buffer", {2'b0, dct_buffer}, 32'd0);
        sb.delete();
        step(2);
        reset_n = 1'b1;
        step(1);
        dct_ready = 1'b1;
        push(30'h3FFFFFFF, 4'd15);
        for (int k = 0; k < 15; k++) send_atom(2'd3);
        wait_drain("t5_drain");
        chk("t5_frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // 6: five frames; the FCNT_W=2 instance wraps to 1
        do_reset();
        dct_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            push(t6_exp[j], 4'd15);
            for (int k = 0; k < 15; k++) send_atom(2'(j));
        end
        wait_drain("t6_drain");
        chk("t6_frame_cnt", {16'd0, frame_cnt}, 32'd5);
        chk("t6_frame_cnt_wrap", {30'd0, u2_frame_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
